// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and operation type for alu_reg32
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_AND = 3'b000;
  localparam alu_op_t ALU_OR  = 3'b001;
  localparam alu_op_t ALU_ADD = 3'b010;
  localparam alu_op_t ALU_XOR = 3'b011;
  localparam alu_op_t ALU_NOR = 3'b100;
  localparam alu_op_t ALU_SRL = 3'b101;
  localparam alu_op_t ALU_SUB = 3'b110;
  localparam alu_op_t ALU_SLT = 3'b111;

  // SLT and SUB both need the subtracting adder
  function automatic logic op_is_sub(input alu_op_t op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - shared adder/subtractor with carry-out and signed overflow
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  // Subtraction is A + ~B + 1, so the carry-in is simply the sub bit
  always_comb begin
    b_eff = b ^ {WIDTH{sub}};
    full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    sum   = full[WIDTH-1:0];
    co    = full[WIDTH];
    // Same-signed effective operands producing a differently-signed sum
    ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_reg32.sv
// rtl/alu_reg32.sv - registered 32-bit ALU with carry, zero and overflow flags
module alu_reg32
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Ctr,
  output logic [WIDTH-1:0] res,
  output logic             Co,
  output logic             zero,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  alu_op_t          op;
  logic [WIDTH-1:0] as_sum;
  logic             as_co;
  logic             as_ovf;
  logic [WIDTH-1:0] res_next;
  logic             co_next;
  logic             ovf_next;
  logic             zero_next;

  assign op = ALU_Ctr;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (A),
    .b   (B),
    .sub (op_is_sub(op)),
    .sum (as_sum),
    .co  (as_co),
    .ovf (as_ovf)
  );

  // Operation mux; flags only come from ADD/SUB, zero is taken from the new result
  always_comb begin
    res_next = '0;
    co_next  = 1'b0;
    ovf_next = 1'b0;
    case (op)
      ALU_AND: res_next = A & B;
      ALU_OR:  res_next = A | B;
      ALU_ADD: begin
        res_next = as_sum;
        co_next  = as_co;
        ovf_next = as_ovf;
      end
      ALU_XOR: res_next = A ^ B;
      ALU_NOR: res_next = ~(A | B);
      ALU_SRL: res_next = A >> B[SHW-1:0];
      ALU_SUB: begin
        res_next = as_sum;
        co_next  = as_co;
        ovf_next = as_ovf;
      end
      // Sign of A-B corrected by overflow gives the true signed less-than
      ALU_SLT: res_next = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
      default: res_next = '0;
    endcase
    zero_next = (res_next == '0);
  end

  // Capture result and flags together so they always describe the same operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res      <= '0;
      Co       <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else begin
      res      <= res_next;
      Co       <= co_next;
      overflow <= ovf_next;
      zero     <= zero_next;
    end
  end

endmodule

// File: tb/tb_alu_reg32.sv
// tb/tb_alu_reg32.sv - scoreboard bench for alu_reg32
module tb_alu_reg32;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALU_Ctr;
  logic [31:0] res;
  logic        Co;
  logic        zero;
  logic        overflow;

  int   checks;
  int   errors;
  exp_t sb[$];

  alu_reg32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .ALU_Ctr  (ALU_Ctr),
    .res      (res),
    .Co       (Co),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    exp_t   e;
    longint s;
    e = '0;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: begin
        e.res = a + b;
        e.co  = ({1'b0, a} + {1'b0, b}) > 33'h0FFFFFFFF;
        s     = longint'($signed(a)) + longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd3: e.res = a ^ b;
      3'd4: e.res = ~(a | b);
      3'd5: e.res = a >> b[4:0];
      3'd6: begin
        e.res = a - b;
        e.co  = (a >= b);
        s     = longint'($signed(a)) - longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      default: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".res"}, res, e.res);
      check({tag, ".co"}, {31'd0, Co}, {31'd0, e.co});
      check({tag, ".zero"}, {31'd0, zero}, {31'd0, e.zero});
      check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
    end
  endtask

  // Drive at negedge, push the expectation, compare just after the next rising edge
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] er, input logic eco,
                       input logic eov);
    exp_t e;
    @(negedge clk);
    A = a; B = b; ALU_Ctr = op;
    e.res = er; e.co = eco; e.ovf = eov; e.zero = (er == 32'd0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  task automatic apply_rand(input int idx);
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    exp_t        e;
    a  = $urandom;
    b  = (idx % 4 == 0) ? a : $urandom;
    op = 3'($urandom_range(0, 7));
    e  = model(a, b, op);
    apply($sformatf("rnd%0d", idx), a, b, op, e.res, e.co, e.ovf);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".res"}, res, 32'd0);
    check({tag, ".co"}, {31'd0, Co}, 32'd0);
    check({tag, ".zero"}, {31'd0, zero}, 32'd1);
    check({tag, ".ovf"}, {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    A = 32'd22222; B = 32'd11111; ALU_Ctr = 3'd2;
    #1 rst_n = 1'b0;
    #1 check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Test-plan sweep over all opcodes with fixed operands
    apply("and", 32'd22222, 32'd11111, ALU_AND, 32'h0000_0246, 1'b0, 1'b0);
    apply("or",  32'd22222, 32'd11111, ALU_OR,  32'h0000_7FEF, 1'b0, 1'b0);
    apply("add", 32'd22222, 32'd11111, ALU_ADD, 32'h0000_8235, 1'b0, 1'b0);
    apply("xor", 32'd22222, 32'd11111, ALU_XOR, 32'h0000_7DA9, 1'b0, 1'b0);
    apply("nor", 32'd22222, 32'd11111, ALU_NOR, 32'hFFFF_8010, 1'b0, 1'b0);
    apply("srl", 32'd22222, 32'd11111, ALU_SRL, 32'h0000_00AD, 1'b0, 1'b0);
    apply("sub", 32'd22222, 32'd11111, ALU_SUB, 32'h0000_2B67, 1'b1, 1'b0);
    apply("slt", 32'd22222, 32'd11111, ALU_SLT, 32'h0000_0000, 1'b0, 1'b0);

    // Arithmetic boundaries
    apply("add_ovf",  32'h7FFF_FFFF, 32'h1, ALU_ADD, 32'h8000_0000, 1'b0, 1'b1);
    apply("add_wrap", 32'hFFFF_FFFF, 32'h1, ALU_ADD, 32'h0000_0000, 1'b1, 1'b0);
    apply("sub_brw",  32'h0,         32'h1, ALU_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0);
    apply("sub_ovf",  32'h8000_0000, 32'h1, ALU_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1);
    apply("slt_neg",  32'hFFFF_FFFF, 32'h1, ALU_SLT, 32'h1, 1'b0, 1'b0);
    apply("slt_ovf",  32'h8000_0000, 32'h7FFF_FFFF, ALU_SLT, 32'h1, 1'b0, 1'b0);
    apply("slt_eq",   32'd5, 32'd5, ALU_SLT, 32'h0, 1'b0, 1'b0);
    apply("srl_0",    32'hDEAD_BEEF, 32'hFFFF_FFE0, ALU_SRL, 32'hDEAD_BEEF, 1'b0, 1'b0);
    apply("srl_31",   32'h8000_0000, 32'd31, ALU_SRL, 32'h1, 1'b0, 1'b0);

    // Mid-cycle operand change must not disturb the registered result
    apply("hold", 32'h1234_0000, 32'h0000_5678, ALU_OR, 32'h1234_5678, 1'b0, 1'b0);
    A = 32'h0; B = 32'h0; ALU_Ctr = ALU_AND;
    #2 check("hold.mid", res, 32'h1234_5678);

    // Async reset between edges clears a nonzero result immediately
    apply("pre_rst", 32'd5, 32'd3, ALU_ADD, 32'd8, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1 check_reset_state("async_rst");
    @(negedge clk);
    A = 32'h0F0; B = 32'h00F; ALU_Ctr = ALU_XOR;
    rst_n = 1'b1;
    sb.push_back('{res: 32'h0FF, co: 1'b0, zero: 1'b0, ovf: 1'b0});
    @(posedge clk);
    #1 pop_check("post_rst");

    // Reset across an edge discards the pending operation
    @(negedge clk);
    A = 32'hFFFF_0000; B = 32'h1; ALU_Ctr = ALU_ADD;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 check_reset_state("discard");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) apply_rand(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
